// File: rtl/data_memory_ctrl.sv
// Word/byte data memory with a fixed-latency IDLE/WAIT/DONE handshake; ready low stalls the pipeline.
// Optional range checking with err is enabled by defining DMEM_BOUNDS_CHECK_EN.
module data_memory_ctrl #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_w_en,
    input  logic              mem_r_en,
    input  logic              size,
    input  logic [31:0]       address,
    input  logic [DATA_W-1:0] dataToWrite,
    output logic [DATA_W-1:0] result,
    output logic              ready,
    output logic              err
);
    localparam int BYTES  = DATA_W / 8;
    localparam int LANE_W = $clog2(BYTES);
    localparam int LW     = (LANE_W > 0) ? LANE_W : 1;
    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [31:0] BASE = 32'(BASE_ADDR);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d, rd_q, rd_d, size_q, size_d;
    logic [31:0]       addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    logic              req, in_idle, go_done, oob, acc_err;
    logic              acc_wr, acc_rd, acc_size;
    logic [31:0]       acc_addr, off, off_sh;
    logic [DATA_W-1:0] acc_wdata, rd_word;
    logic [IDX_W-1:0]  idx;
    logic [LW-1:0]     lane;
    logic [7:0]        rd_byte;
    logic              unused_off;

    assign req     = mem_w_en | mem_r_en;
    assign in_idle = (state_q == S_IDLE);

    // The access completing this edge comes straight from the ports when
    // IDLE jumps directly to DONE, otherwise from the latched request.
    assign acc_wr    = in_idle ? mem_w_en               : wr_q;
    assign acc_rd    = in_idle ? (mem_r_en & ~mem_w_en) : rd_q;
    assign acc_size  = in_idle ? size                   : size_q;
    assign acc_addr  = in_idle ? address                : addr_q;
    assign acc_wdata = in_idle ? dataToWrite            : wdata_q;

    assign off        = acc_addr - BASE;
    assign off_sh     = off >> LANE_W;
    assign idx        = off_sh[IDX_W-1:0];
    assign lane       = (LANE_W == 0) ? '0 : off[LW-1:0];
    assign unused_off = ^off_sh[31:IDX_W];

    assign rd_word = mem_q[idx];
    assign rd_byte = rd_word[{lane, 3'b000} +: 8];

    assign go_done = ~rst & ((in_idle & req & (WAIT_CYCLES == 0)) |
                             ((state_q == S_WAIT) & (cnt_q == 4'd1)));

`ifdef DMEM_BOUNDS_CHECK_EN
    logic err_q;
    assign oob = (acc_addr < BASE) | (off >= 32'(DEPTH_WORDS * BYTES));

    // Set on the edge entering DONE; DONE lasts one cycle so err is DONE-only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= go_done & oob;
    end
    assign acc_err = err_q;
    assign err     = err_q;
`else
    assign oob     = 1'b0;
    assign acc_err = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    wr_d    = mem_w_en;
                    rd_d    = mem_r_en & ~mem_w_en;
                    size_d  = size;
                    addr_d  = address;
                    wdata_d = dataToWrite;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        if (go_done & acc_rd & ~oob)
            rdata_d = acc_size ? DATA_W'(rd_byte) : rd_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            size_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Array is deliberately outside reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (go_done & acc_wr & ~oob) begin
            if (acc_size) mem_q[idx][{lane, 3'b000} +: 8] <= acc_wdata[7:0];
            else          mem_q[idx] <= acc_wdata;
        end
    end

    assign ready  = (state_q == S_DONE) | (in_idle & ~req);
    assign result = ((state_q == S_DONE) && rd_q && !acc_err) ? rdata_q : '0;

endmodule
